xphy_cfg_seq: RTL and testbench

- Sequencer that owns the 10GBASE-R core's training/management interface after PHY reset release.
- Issues a fixed, parameterised list of register writes, then polls a status register until a masked bit set is seen, with timeouts and bounded retries.
- Reports busy/done/error to the MAC wrapper.
- Replaces the tied-off training outputs in the PHY interface shim. All logic runs on clk156.

---
 rtl/xphy_cfg_seq_if.sv | 25 ++
 rtl/xphy_cfg_seq.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_xphy_cfg_seq.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xphy_cfg_seq_if.sv
// Training/management bus between the configuration sequencer (master)
// and the 10GBASE-R core's register port (slave).
interface xphy_cfg_seq_if;
  logic        training_enable;
  logic [20:0] training_addr;
  logic        training_rnw;
  logic [15:0] training_wrdata;
  logic        training_ipif_cs;
  logic        training_drp_cs;
  logic [15:0] training_rddata;
  logic        training_rdack;
  logic        training_wrack;

  modport master (
    output training_enable, training_addr, training_rnw, training_wrdata,
           training_ipif_cs, training_drp_cs,
    input  training_rddata, training_rdack, training_wrack
  );

  modport slave (
    input  training_enable, training_addr, training_rnw, training_wrdata,
           training_ipif_cs, training_drp_cs,
    output training_rddata, training_rdack, training_wrack
  );
endinterface

// File: rtl/xphy_cfg_seq.sv
// xphy_cfg_seq: takes ownership of the 10GBASE-R training/management port once
// the PHY is ready, writes a short register table, then polls a status register
// until all masked bits read 1. Ack timeouts and poll exhaustion trigger a
// back-off and restart; too many failed attempts end in ERROR.
// Optional build macro XPHY_CFG_READBACK_EN: every acked write is followed by a
// read of the same address, and a data mismatch counts as a failed attempt.
module xphy_cfg_seq #(
  parameter logic [20:0] C_WR0_ADDR    = 21'h01_0000,
  parameter logic [15:0] C_WR0_DATA    = 16'h2040,
  parameter logic [20:0] C_WR1_ADDR    = 21'h03_0000,
  parameter logic [15:0] C_WR1_DATA    = 16'h2040,
  parameter int unsigned C_NUM_WR      = 2,
  parameter logic [20:0] C_POLL_ADDR   = 21'h03_0020,
  parameter logic [15:0] C_POLL_MASK   = 16'h0001,
  parameter int unsigned C_ACK_TIMEOUT = 1023,
  parameter int unsigned C_POLL_GAP    = 255,
  parameter int unsigned C_POLL_LIMIT  = 64,
  parameter int unsigned C_RETRY_MAX   = 3
) (
  input  logic           clk156,
  input  logic           rst_n,
  input  logic           start,
  xphy_cfg_seq_if.master trn,
  output logic           cfg_busy,
  output logic           cfg_done,
  output logic           cfg_error,
  output logic [15:0]    status_rd,
  output logic [1:0]     retry_cnt
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ISSUE,
    S_WR_WAIT,
`ifdef XPHY_CFG_READBACK_EN
    S_RB_ISSUE,
    S_RB_WAIT,
`endif
    S_POLL_ISSUE,
    S_POLL_WAIT,
    S_POLL_GAP,
    S_BACKOFF,
    S_DONE,
    S_ERROR
  } state_t;

  // With an empty write table the sequence opens directly with a poll.
  localparam state_t S_FIRST = (C_NUM_WR == 0) ? S_POLL_ISSUE : S_WR_ISSUE;

  state_t      state_q, state_d;
  logic [15:0] wr_idx_q, wr_idx_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic [15:0] ack_cnt_q, ack_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [1:0]  retry_q, retry_d;
  logic [15:0] status_q, status_d;
  logic [20:0] addr_q, addr_d;
  logic        rnw_q, rnw_d;
  logic [15:0] wrdata_q, wrdata_d;
  logic        busy;

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  // True on the cycle in which a counter that started at 0 completes lim cycles.
  function automatic logic expired(input logic [15:0] cnt, input int unsigned lim);
    return (32'(cnt) + 32'd1) >= lim;
  endfunction

  function automatic logic [20:0] tbl_addr(input logic [15:0] idx);
    return (idx == 16'd0) ? C_WR0_ADDR : C_WR1_ADDR;
  endfunction

  function automatic logic [15:0] tbl_data(input logic [15:0] idx);
    return (idx == 16'd0) ? C_WR0_DATA : C_WR1_DATA;
  endfunction

  // State and datapath registers; reset leaves the port idle with rnw=1.
  always_ff @(posedge clk156) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_idx_q   <= '0;
      poll_cnt_q <= '0;
      ack_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      retry_q    <= '0;
      status_q   <= '0;
      addr_q     <= '0;
      rnw_q      <= 1'b1;
      wrdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      poll_cnt_q <= poll_cnt_d;
      ack_cnt_q  <= ack_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      retry_q    <= retry_d;
      status_q   <= status_d;
      addr_q     <= addr_d;
      rnw_q      <= rnw_d;
      wrdata_q   <= wrdata_d;
    end
  end

  // Next-state, counter and request-register update logic.
  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    poll_cnt_d = poll_cnt_q;
    ack_cnt_d  = ack_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    retry_d    = retry_q;
    status_d   = status_q;
    addr_d     = addr_q;
    rnw_d      = rnw_q;
    wrdata_d   = wrdata_q;

    if ((state_q != S_IDLE) && !start) begin
      // Abort: release the port at once; a late ack lands in IDLE and is ignored.
      state_d = S_IDLE;
      retry_d = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            wr_idx_d   = '0;
            poll_cnt_d = '0;
            state_d    = S_FIRST;
          end
        end

        S_WR_ISSUE: begin
          ack_cnt_d = '0;
          state_d   = S_WR_WAIT;
        end

        S_WR_WAIT: begin
          // Ack is checked ahead of the timeout so a coincident ack wins.
          if (trn.training_wrack) begin
`ifdef XPHY_CFG_READBACK_EN
            state_d = S_RB_ISSUE;
`else
            wr_idx_d = sat_inc16(wr_idx_q);
            state_d  = (32'(wr_idx_d) < C_NUM_WR) ? S_WR_ISSUE : S_POLL_ISSUE;
`endif
          end else if (expired(ack_cnt_q, C_ACK_TIMEOUT)) begin
            state_d = S_BACKOFF;
          end else begin
            ack_cnt_d = sat_inc16(ack_cnt_q);
          end
        end

`ifdef XPHY_CFG_READBACK_EN
        S_RB_ISSUE: begin
          ack_cnt_d = '0;
          state_d   = S_RB_WAIT;
        end

        S_RB_WAIT: begin
          if (trn.training_rdack) begin
            if (trn.training_rddata == wrdata_q) begin
              wr_idx_d = sat_inc16(wr_idx_q);
              state_d  = (32'(wr_idx_d) < C_NUM_WR) ? S_WR_ISSUE : S_POLL_ISSUE;
            end else begin
              state_d = S_BACKOFF;
            end
          end else if (expired(ack_cnt_q, C_ACK_TIMEOUT)) begin
            state_d = S_BACKOFF;
          end else begin
            ack_cnt_d = sat_inc16(ack_cnt_q);
          end
        end
`endif

        S_POLL_ISSUE: begin
          ack_cnt_d = '0;
          state_d   = S_POLL_WAIT;
        end

        S_POLL_WAIT: begin
          if (trn.training_rdack) begin
            status_d = trn.training_rddata;
            if ((trn.training_rddata & C_POLL_MASK) == C_POLL_MASK) begin
              state_d = S_DONE;
            end else begin
              poll_cnt_d = sat_inc16(poll_cnt_q);
              state_d    = expired(poll_cnt_q, C_POLL_LIMIT) ? S_BACKOFF : S_POLL_GAP;
            end
          end else if (expired(ack_cnt_q, C_ACK_TIMEOUT)) begin
            state_d = S_BACKOFF;
          end else begin
            ack_cnt_d = sat_inc16(ack_cnt_q);
          end
        end

        S_POLL_GAP: begin
          if (expired(gap_cnt_q, C_POLL_GAP)) begin
            state_d = S_POLL_ISSUE;
          end else begin
            gap_cnt_d = sat_inc16(gap_cnt_q);
          end
        end

        S_BACKOFF: begin
          // retry_q already includes the attempt that just failed.
          if (32'(retry_q) >= C_RETRY_MAX) begin
            state_d = S_ERROR;
          end else if (expired(gap_cnt_q, C_POLL_GAP)) begin
            wr_idx_d   = '0;
            poll_cnt_d = '0;
            state_d    = S_FIRST;
          end else begin
            gap_cnt_d = sat_inc16(gap_cnt_q);
          end
        end

        S_DONE, S_ERROR: ;

        default: state_d = S_IDLE;
      endcase
    end

    // Entering a timed wait restarts its timer; entering BACKOFF logs a failure.
    if (state_d != state_q) begin
      if ((state_d == S_POLL_GAP) || (state_d == S_BACKOFF)) begin
        gap_cnt_d = '0;
      end
      if (state_d == S_BACKOFF) begin
        retry_d = sat_inc2(retry_q);
      end
      // Request fields are latched on entry to an ISSUE state and then held.
      case (state_d)
        S_WR_ISSUE: begin
          addr_d   = tbl_addr(wr_idx_d);
          rnw_d    = 1'b0;
          wrdata_d = tbl_data(wr_idx_d);
        end
        S_POLL_ISSUE: begin
          addr_d = C_POLL_ADDR;
          rnw_d  = 1'b1;
        end
`ifdef XPHY_CFG_READBACK_EN
        S_RB_ISSUE: rnw_d = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    busy                 = 1'b0;
    cfg_done             = 1'b0;
    cfg_error            = 1'b0;
    trn.training_ipif_cs = 1'b0;
    case (state_q)
      S_IDLE:  ;
      S_DONE:  cfg_done  = 1'b1;
      S_ERROR: cfg_error = 1'b1;
      S_WR_ISSUE, S_POLL_ISSUE: begin
        busy                 = 1'b1;
        trn.training_ipif_cs = 1'b1;
      end
`ifdef XPHY_CFG_READBACK_EN
      S_RB_ISSUE: begin
        busy                 = 1'b1;
        trn.training_ipif_cs = 1'b1;
      end
`endif
      default: busy = 1'b1;
    endcase
    cfg_busy            = busy;
    trn.training_enable = busy;
  end

  assign trn.training_addr   = addr_q;
  assign trn.training_rnw    = rnw_q;
  assign trn.training_wrdata = wrdata_q;
  assign trn.training_drp_cs = 1'b0;
  assign status_rd           = status_q;
  assign retry_cnt           = retry_q;

endmodule

// File: tb/tb_xphy_cfg_seq.sv
// Scoreboard bench for xphy_cfg_seq: scenarios push expected requests
// (address, direction, data, cycles since previous strobe) into a queue; a
// monitor pops one entry per request strobe. A responder models the core's
// register port with a programmable ack latency.
module tb_xphy_cfg_seq;

  localparam logic [20:0] WR0_A  = 21'h01_0000;
  localparam logic [20:0] WR1_A  = 21'h03_0000;
  localparam logic [20:0] POLL_A = 21'h03_0020;
  localparam logic [15:0] WDAT   = 16'h2040;
`ifdef XPHY_CFG_READBACK_EN
  localparam int RBK = 1;
`else
  localparam int RBK = 0;
`endif

  typedef struct {
    logic [20:0] addr;
    logic        rnw;
    logic        chk_data;
    logic [15:0] data;
    int          gap;
  } req_t;

  logic        clk156;
  logic        rst_n;
  logic        start;
  logic        cfg_busy, cfg_done, cfg_error;
  logic [15:0] status_rd;
  logic [1:0]  retry_cnt;

  xphy_cfg_seq_if ifc ();

  xphy_cfg_seq dut (
    .clk156    (clk156),
    .rst_n     (rst_n),
    .start     (start),
    .trn       (ifc),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_error (cfg_error),
    .status_rd (status_rd),
    .retry_cnt (retry_cnt)
  );

  req_t        exp_q[$];
  logic [15:0] poll_q[$];
  int          checks;
  int          errors;
  int          cs_seen;
  int          ack_lat;
  int          rb_bad;
  logic        wr_ack_en;
  logic [15:0] rd_default;

  initial begin
    clk156 = 1'b0;
    forever #5 clk156 = ~clk156;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [20:0] a, input logic rnw, input logic cd,
                      input logic [15:0] d, input int gap);
    req_t r;
    r.addr = a; r.rnw = rnw; r.chk_data = cd; r.data = d; r.gap = gap;
    exp_q.push_back(r);
  endtask

  // The write table, each write followed by its readback when that is built in.
  task automatic push_writes(input int lat, input int first_gap);
    push(WR0_A, 1'b0, 1'b1, WDAT, first_gap);
`ifdef XPHY_CFG_READBACK_EN
    push(WR0_A, 1'b1, 1'b0, 16'h0, lat + 1);
`endif
    push(WR1_A, 1'b0, 1'b1, WDAT, lat + 1);
`ifdef XPHY_CFG_READBACK_EN
    push(WR1_A, 1'b1, 1'b0, 16'h0, lat + 1);
`endif
  endtask

  task automatic wait_cs(input int target, input int limit, input string name);
    int n;
    n = 0;
    while (cs_seen < target && n < limit) begin
      @(negedge clk156);
      n++;
    end
    check(name, cs_seen, target);
  endtask

  task automatic wait_flag(input logic want_err, input int limit, input string name);
    int n;
    n = 0;
    while (((want_err ? cfg_error : cfg_done) !== 1'b1) && n < limit) begin
      @(negedge clk156);
      n++;
    end
    check(name, 32'(want_err ? cfg_error : cfg_done), 32'd1);
  endtask

  task automatic abort_seq();
    start = 1'b0;
    repeat (15) @(negedge clk156);
  endtask

  // Monitor: one scoreboard entry per request strobe.
  initial begin : monitor
    int   cyc;
    int   last_cyc;
    logic prev_cs;
    req_t e;
    cyc = 0; last_cyc = 0; prev_cs = 1'b0;
    forever begin
      @(negedge clk156);
      cyc++;
      if (ifc.training_ipif_cs === 1'b1) begin
        check("cs_single_cycle", 32'(prev_cs), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cs: addr %0h rnw %0b with no expected request",
                   ifc.training_addr, ifc.training_rnw);
        end else begin
          e = exp_q.pop_front();
          check("req_addr", 32'(ifc.training_addr), 32'(e.addr));
          check("req_rnw", 32'(ifc.training_rnw), 32'(e.rnw));
          if (e.chk_data) check("req_wrdata", 32'(ifc.training_wrdata), 32'(e.data));
          if (e.gap >= 0) check("req_gap", cyc - last_cyc, e.gap);
        end
        last_cyc = cyc;
        cs_seen++;
      end
      prev_cs = ifc.training_ipif_cs;
    end
  end

  // Responder: acks each request ack_lat cycles after its strobe.
  initial begin : responder
    int          pend;
    logic        prnw;
    logic [20:0] paddr;
    logic [15:0] last_wd;
    pend = 0; prnw = 1'b0; paddr = '0; last_wd = '0;
    ifc.training_rdack  = 1'b0;
    ifc.training_wrack  = 1'b0;
    ifc.training_rddata = '0;
    forever begin
      @(negedge clk156);
      ifc.training_rdack = 1'b0;
      ifc.training_wrack = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (!prnw) begin
            if (wr_ack_en) ifc.training_wrack = 1'b1;
          end else begin
            if (paddr == POLL_A) begin
              if (poll_q.size() > 0) ifc.training_rddata = poll_q.pop_front();
              else                   ifc.training_rddata = rd_default;
            end else if (rb_bad > 0) begin
              ifc.training_rddata = last_wd + 16'd1;
              rb_bad--;
            end else begin
              ifc.training_rddata = last_wd;
            end
            ifc.training_rdack = 1'b1;
          end
        end
      end
      if (ifc.training_ipif_cs === 1'b1) begin
        pend  = ack_lat;
        prnw  = ifc.training_rnw;
        paddr = ifc.training_addr;
        if (!ifc.training_rnw) last_wd = ifc.training_wrdata;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int base;
    checks = 0; errors = 0; cs_seen = 0;
    ack_lat = 3; rb_bad = 0; wr_ack_en = 1'b1; rd_default = 16'h0000;
    rst_n = 1'b0;
    start = 1'b1;

    // Reset held with start high: port idle, rnw high, everything else 0.
    repeat (4) @(negedge clk156);
    check("rst_enable", 32'(ifc.training_enable), 32'd0);
    check("rst_cs", 32'(ifc.training_ipif_cs), 32'd0);
    check("rst_drp_cs", 32'(ifc.training_drp_cs), 32'd0);
    check("rst_addr", 32'(ifc.training_addr), 32'd0);
    check("rst_rnw", 32'(ifc.training_rnw), 32'd1);
    check("rst_wrdata", 32'(ifc.training_wrdata), 32'd0);
    check("rst_busy", 32'(cfg_busy), 32'd0);
    check("rst_done", 32'(cfg_done), 32'd0);
    check("rst_error", 32'(cfg_error), 32'd0);
    check("rst_status", 32'(status_rd), 32'd0);
    check("rst_retry", 32'(retry_cnt), 32'd0);

    // Normal run: two writes, polls read 0, 0, 1 with 255 idle cycles between.
    push_writes(3, -1);
    push(POLL_A, 1'b1, 1'b0, 16'h0, 4);
    push(POLL_A, 1'b1, 1'b0, 16'h0, 259);
    push(POLL_A, 1'b1, 1'b0, 16'h0, 259);
    poll_q.push_back(16'h0000);
    poll_q.push_back(16'h0000);
    poll_q.push_back(16'h0001);
    rst_n = 1'b1;
    wait_flag(1'b0, 3000, "normal_done");
    check("normal_status", 32'(status_rd), 32'h0001);
    check("normal_retry", 32'(retry_cnt), 32'd0);
    check("normal_busy", 32'(cfg_busy), 32'd0);
    check("normal_enable", 32'(ifc.training_enable), 32'd0);
    check("normal_cs_count", cs_seen, 5 + 2 * RBK);
    repeat (20) @(negedge clk156);
    check("done_holds", 32'(cfg_done), 32'd1);
    check("normal_queue_empty", exp_q.size(), 0);

    // No write ack at all: three timed-out attempts, then ERROR.
    abort_seq();
    check("abort_done_clear", 32'(cfg_done), 32'd0);
    wr_ack_en = 1'b0;
    push(WR0_A, 1'b0, 1'b1, WDAT, -1);
    push(WR0_A, 1'b0, 1'b1, WDAT, 1279);
    push(WR0_A, 1'b0, 1'b1, WDAT, 1279);
    base = cs_seen;
    start = 1'b1;
    wait_cs(base + 2, 2000, "timeout_second_attempt");
    check("timeout_retry1", 32'(retry_cnt), 32'd1);
    check("timeout_busy_retrying", 32'(cfg_busy), 32'd1);
    wait_flag(1'b1, 4000, "timeout_error");
    check("error_retry", 32'(retry_cnt), 32'd3);
    check("error_busy", 32'(cfg_busy), 32'd0);
    check("error_enable", 32'(ifc.training_enable), 32'd0);
    check("error_done", 32'(cfg_done), 32'd0);
    repeat (20) @(negedge clk156);
    check("error_holds", 32'(cfg_error), 32'd1);
    check("timeout_queue_empty", exp_q.size(), 0);
    abort_seq();
    check("abort_retry_clear", 32'(retry_cnt), 32'd0);
    check("abort_error_clear", 32'(cfg_error), 32'd0);
    wr_ack_en = 1'b1;

    // Status never set: 64 polls, back-off, writes reissued.
    rd_default = 16'h0000;
    push_writes(3, -1);
    push(POLL_A, 1'b1, 1'b0, 16'h0, 4);
    for (int i = 1; i < 64; i++) push(POLL_A, 1'b1, 1'b0, 16'h0, 259);
    push(WR0_A, 1'b0, 1'b1, WDAT, 259);
    base = cs_seen;
    start = 1'b1;
    wait_cs(base + 2 * (1 + RBK) + 65, 20000, "poll_limit_rewrite");
    check("poll_limit_retry", 32'(retry_cnt), 32'd1);
    check("poll_limit_status", 32'(status_rd), 32'h0000);
    check("poll_limit_busy", 32'(cfg_busy), 32'd1);
    abort_seq();
    check("poll_abort_retry", 32'(retry_cnt), 32'd0);
    check("poll_queue_empty", exp_q.size(), 0);

    // Abort while a poll is outstanding; its late rdack (data 1) must be ignored.
    ack_lat = 10;
    rd_default = 16'h0001;
    push_writes(10, -1);
    push(POLL_A, 1'b1, 1'b0, 16'h0, 11);
    base = cs_seen;
    start = 1'b1;
    wait_cs(base + 2 * (1 + RBK) + 1, 300, "midpoll_reach_poll");
    repeat (2) @(negedge clk156);
    start = 1'b0;
    @(negedge clk156);
    check("midpoll_enable", 32'(ifc.training_enable), 32'd0);
    check("midpoll_busy", 32'(cfg_busy), 32'd0);
    check("midpoll_cs", 32'(ifc.training_ipif_cs), 32'd0);
    repeat (15) @(negedge clk156);
    check("late_ack_status", 32'(status_rd), 32'h0000);
    check("late_ack_done", 32'(cfg_done), 32'd0);
    check("midpoll_queue_empty", exp_q.size(), 0);

    // Restart after the abort begins again at WR0.
    ack_lat = 3;
    push_writes(3, -1);
    push(POLL_A, 1'b1, 1'b0, 16'h0, 4);
    start = 1'b1;
    wait_flag(1'b0, 300, "restart_done");
    check("restart_status", 32'(status_rd), 32'h0001);
    check("restart_retry", 32'(retry_cnt), 32'd0);

    // Ack on the last cycle before timeout expiry is accepted.
    abort_seq();
    ack_lat = 1023;
    push_writes(1023, -1);
    push(POLL_A, 1'b1, 1'b0, 16'h0, 1024);
    start = 1'b1;
    wait_flag(1'b0, 8000, "late_ack_wins_done");
    check("late_ack_wins_retry", 32'(retry_cnt), 32'd0);
    check("late_ack_wins_queue", exp_q.size(), 0);

`ifdef XPHY_CFG_READBACK_EN
    // Readback returns 16'h2041: back-off, then a matching readback proceeds.
    abort_seq();
    ack_lat = 3;
    rb_bad = 1;
    push(WR0_A, 1'b0, 1'b1, WDAT, -1);
    push(WR0_A, 1'b1, 1'b0, 16'h0, 4);
    push(WR0_A, 1'b0, 1'b1, WDAT, 259);
    push(WR0_A, 1'b1, 1'b0, 16'h0, 4);
    push(WR1_A, 1'b0, 1'b1, WDAT, 4);
    push(WR1_A, 1'b1, 1'b0, 16'h0, 4);
    push(POLL_A, 1'b1, 1'b0, 16'h0, 4);
    base = cs_seen;
    start = 1'b1;
    wait_cs(base + 3, 600, "rb_mismatch_rewrite");
    check("rb_mismatch_retry", 32'(retry_cnt), 32'd1);
    wait_flag(1'b0, 600, "rb_done");
    check("rb_done_retry", 32'(retry_cnt), 32'd1);
    check("rb_queue_empty", exp_q.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
